game_flow_ctrl: RTL



---
 rtl/game_pkg.sv | 18 +
 rtl/game_sec_timer.sv | 43 ++++
 rtl/game_flow_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: state encodings and default tuning values.
// The display and text blocks import this package as well.
package game_pkg;

  typedef enum logic [1:0] {
    INTRO_ST    = 2'd0,
    PLAY_ST     = 2'd1,
    GAMEOVER_ST = 2'd2,
    ENDING_ST   = 2'd3
  } game_state_t;

  localparam int DEF_START_LIVES    = 3;
  localparam int DEF_COIN_GOAL      = 10;
  localparam int DEF_TIME_LIMIT     = 99;
  localparam int DEF_FRAMES_PER_SEC = 60;
  localparam int DEF_INVULN_FRAMES  = 120;

endpackage

// File: rtl/game_sec_timer.sv
// Play-time countdown: divides frame ticks into seconds and counts time_left down.
// expire pulses combinationally on the enabled tick that takes time_left from 1 to 0.
module game_sec_timer
  import game_pkg::*;
#(
  parameter int TIME_LIMIT     = DEF_TIME_LIMIT,
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       en,
  output logic [6:0] time_left,
  output logic       expire
);

  localparam logic [7:0] FRAME_LAST = 8'(FRAMES_PER_SEC - 1);
  localparam logic [6:0] TIME_INIT  = 7'(TIME_LIMIT);

  logic [7:0] frame_cnt;
  logic       wrap;

  assign wrap   = en && (frame_cnt == FRAME_LAST);
  assign expire = wrap && (time_left == 7'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 8'd0;
      time_left <= TIME_INIT;
    end else if (load) begin
      frame_cnt <= 8'd0;
      time_left <= TIME_INIT;
    end else if (en) begin
      if (wrap) begin
        frame_cnt <= 8'd0;
        if (time_left != 7'd0) time_left <= time_left - 7'd1;
      end else begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow controller: INTRO/PLAY/GAMEOVER/ENDING sequencing with lives, coins,
// play timer and post-hit invulnerability window.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int START_LIVES    = DEF_START_LIVES,
  parameter int COIN_GOAL      = DEF_COIN_GOAL,
  parameter int TIME_LIMIT     = DEF_TIME_LIMIT,
  parameter int FRAMES_PER_SEC = DEF_FRAMES_PER_SEC,
  parameter int INVULN_FRAMES  = DEF_INVULN_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_pulse,
  input  logic       mario_hit,
  input  logic       reach_coin,
  input  logic       god_mode,
  output logic [1:0] game_st,
  output logic       play_rst,
  output logic [1:0] lives,
  output logic [3:0] coins,
  output logic [6:0] time_left,
  output logic       invuln,
  output logic       blink
);

  localparam logic [1:0] LIVES_INIT  = 2'(START_LIVES);
  localparam logic [4:0] GOAL        = 5'(COIN_GOAL);
  localparam logic [7:0] INVULN_INIT = 8'(INVULN_FRAMES);

  game_state_t state;
  logic [7:0]  inv_cnt;
  logic        coin_prev;
  logic        in_play;
  logic        coin_acc;
  logic        hit_acc;
  logic        goal_hit;
  logic        fatal_hit;
  logic        time_expire;
  logic        timer_load;
  logic        timer_en;

  assign in_play    = (state == PLAY_ST);
  assign coin_acc   = in_play && reach_coin && !coin_prev;
  assign hit_acc    = in_play && mario_hit && !god_mode && (inv_cnt == 8'd0);
  assign goal_hit   = coin_acc && (({1'b0, coins} + 5'd1) == GOAL);
  assign fatal_hit  = hit_acc && (lives == 2'd1);
  assign timer_load = (state == INTRO_ST) && start_pulse;
  assign timer_en   = in_play && frame_tick;

  assign game_st  = state;
  assign play_rst = !in_play;
  assign invuln   = (inv_cnt != 8'd0);
  assign blink    = invuln && inv_cnt[3];

  game_sec_timer #(
    .TIME_LIMIT    (TIME_LIMIT),
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_sec_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .en       (timer_en),
    .time_left(time_left),
    .expire   (time_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INTRO_ST;
      lives     <= LIVES_INIT;
      coins     <= 4'd0;
      inv_cnt   <= 8'd0;
      coin_prev <= 1'b0;
    end else begin
      coin_prev <= reach_coin;
      // Invulnerability drains on frame ticks; a hit load below overrides this.
      if (frame_tick && inv_cnt != 8'd0) inv_cnt <= inv_cnt - 8'd1;

      case (state)
        INTRO_ST: begin
          if (start_pulse) begin
            state   <= PLAY_ST;
            lives   <= LIVES_INIT;
            coins   <= 4'd0;
            inv_cnt <= 8'd0;
          end
        end
        PLAY_ST: begin
          if (coin_acc && coins != 4'hF) coins <= coins + 4'd1;
          if (hit_acc) begin
            if (lives != 2'd0) lives <= lives - 2'd1;
            inv_cnt <= INVULN_INIT;
          end
          // Reaching the goal wins even when the same cycle also ends the game.
          if (goal_hit)                      state <= ENDING_ST;
          else if (fatal_hit || time_expire) state <= GAMEOVER_ST;
        end
        GAMEOVER_ST, ENDING_ST: begin
          if (start_pulse) state <= INTRO_ST;
        end
        default: state <= INTRO_ST;
      endcase
    end
  end

endmodule
